lbist_ctrl: RTL and testbench
=============================

Name: lbist_ctrl

Overview:
- Logic-BIST controller between the DFT test pins and the inserted scan chains of croc_soc.
- An LFSR pseudo-random pattern generator (PRPG) feeds the scan chains; a MISR compacts the chain outputs.
- The controller sequences shift and capture cycles over a fixed pattern count, then compares the final signature against a golden value.
- Its start/result interface is driven by the DFT TAP on the dedicated test pads.

Parameters:
- NumChains, 8, number of scan chains; must satisfy 1 ≤ NumChains ≤ MisrWidth.
- ChainLen, 64, shift cycles per pattern (longest chain).
- PatternCnt, 1024, number of capture patterns; must be ≥ 1.
- LfsrWidth, 32, PRPG width; must be ≥ NumChains.
- MisrWidth, 32, signature width.
- Seed, 32'hACE1_0001, PRPG load value; must be nonzero.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  single-cycle start pulse; sampled in IDLE only.
- golden_i  in  MisrWidth  expected signature; sampled in COMPARE.
- scan_en_o  out  1  scan enable to all chains.
- capture_o  out  1  one-cycle functional capture enable.
- scan_in_o  out  NumChains  serial data into the chains.
- scan_out_i  in  NumChains  serial data out of the chains.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  sticky completion flag.
- pass_o  out  1  sticky result; valid when done_o=1.
- signature_o  out  MisrWidth  current MISR contents.

Behaviour:
- Reset: a synchronous rst_i=1 at a clock edge has these effects.
  - FSM goes to IDLE.
  - LFSR loads Seed; MISR clears to 0; all counters clear to 0.
  - All outputs go to 0, including done_o, pass_o and signature_o.
  - Reset asserted mid-operation aborts the run immediately with the same result. No partial result is retained.
- FSM states: IDLE → INIT → SHIFT ⇄ CAPTURE → UNLOAD → COMPARE → IDLE.
- IDLE
  - start_i=1 moves to INIT and clears done_o and pass_o.
  - start_i is ignored in every other state.
- INIT (1 cycle)
  - LFSR loads Seed; MISR clears; pat_cnt=0; shift_cnt=0.
- SHIFT (ChainLen cycles)
  - scan_en_o=1.
  - scan_in_o[k]=lfsr[k]; the LFSR advances one step every cycle.
  - The MISR compacts scan_out_i every cycle except while pat_cnt==0, where chain contents are unknown.
  - After the last shift cycle, go to CAPTURE.
- CAPTURE (1 cycle)
  - scan_en_o=0, capture_o=1; pat_cnt increments.
  - If the new pat_cnt==PatternCnt, go to UNLOAD; otherwise go to SHIFT with shift_cnt=0.
- UNLOAD (ChainLen cycles)
  - scan_en_o=1; scan_in_o=0; the LFSR holds; the MISR compacts every cycle.
- COMPARE (1 cycle)
  - pass_o <= (misr==golden_i); done_o <= 1; go to IDLE.
- Latency: busy_o is high for exactly 1 + PatternCnt·(ChainLen+1) + ChainLen + 1 cycles after the cycle in which start_i is sampled.
- LFSR: Fibonacci, polynomial x^32+x^22+x^2+x+1 (LFSR_POLY), shifting toward the MSB.
- MISR update: misr_n = {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ zero_extend(scan_out_i).
  - MISR_POLY encodes x^32+x^26+x^23+x^22+x^16+x^12+x^11+x^10+x^8+x^7+x^5+x^4+x^2+x+1.
- Counters: shift_cnt is $clog2(ChainLen+1) wide; pat_cnt is $clog2(PatternCnt+1) wide. Neither counter wraps within a run.
- signature_o tracks the MISR continuously. It holds its final value in IDLE until the next INIT.

Optional Feature:
- Macro: LBIST_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in any busy state returns the FSM to IDLE at the next edge, with done_o=1 and pass_o=0. The MISR holds its value.
  - abort_i in IDLE has no effect.
- Undefined: the port is absent; runs complete only by finishing the sequence or by rst_i.

Decomposition:
- lbist_pkg holds:
  - the state enum lbist_state_e {IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE};
  - LFSR_POLY, MISR_POLY and DEFAULT_SEED;
  - the function lfsr_step().
- Sub-module lbist_misr (parameter MisrWidth, NumIn): clk_i, rst_i, clear_i, en_i, data_i, sig_o. It is reusable for other chains.

Test Plan:
- Latency: NumChains=2, ChainLen=4, PatternCnt=3, start pulse → busy_o high for exactly 21 cycles; done_o rises on cycle 22; capture_o pulses exactly 3 times, spaced 5 cycles apart.
- Zero response: scan_out_i tied to 0, golden_i=0 → pass_o=1 and signature_o=0. With golden_i=32'h1 → pass_o=0.
- Chain model: bench shift-register model of 2 chains × 4 flops (capture = invert contents) with a reference-model golden → pass_o=1. Flipping one flop bit at pattern 2 → pass_o=0.
- start_i held high throughout a run → exactly one run occurs; it restarts only after a start_i pulse in IDLE.
- rst_i asserted during the 3rd SHIFT cycle → next cycle: IDLE, all outputs 0. A new start then gives a signature identical to an uninterrupted run.
- With LBIST_ABORT_EN: abort_i in CAPTURE of pattern 2 → IDLE next cycle, done_o=1, pass_o=0, busy_o=0.

Source files
------------

// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared definitions for the logic-BIST controller:
//   lbist_state_e : controller FSM state encoding
//   LFSR_POLY     : PRPG feedback tap mask for x^32+x^22+x^2+x+1
//   MISR_POLY     : signature polynomial x^32+x^26+...+x+1 (low 32 coefficients)
//   DEFAULT_SEED  : PRPG load value after reset / INIT
//   lfsr_step()   : one Fibonacci PRPG step, shifting toward the MSB
// -----------------------------------------------------------------------------
package lbist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SHIFT,
      CAPTURE,
      UNLOAD,
      COMPARE
   } lbist_state_e;

   // Each polynomial term x^k (k = 32, 22, 2, 1) taps state bit k-1. The
   // constant term is implicit in the shift itself.
   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_POLY)};
   endfunction

endpackage

// File: rtl/lbist_misr.sv
// -----------------------------------------------------------------------------
// lbist_misr
// Multiple-input signature register (Galois form). Reusable for any chain set.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   synchronous active-high reset, clears signature
//   clear_i  in   synchronous clear, same effect as reset
//   en_i     in   compact data_i into the signature this cycle
//   data_i   in   NumIn parallel serial-chain outputs (zero-extended)
//   sig_o    out  current signature
// -----------------------------------------------------------------------------
module lbist_misr
   import lbist_pkg::*;
#(
   parameter int MisrWidth = 32,
   parameter int NumIn     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [NumIn-1:0]     data_i,
   output logic [MisrWidth-1:0] sig_o
);

   localparam logic [MisrWidth-1:0] Poly = MisrWidth'(MISR_POLY);

   logic [MisrWidth-1:0] sig_q;
   logic [MisrWidth-1:0] sig_n;

   always_comb begin
      sig_n = {sig_q[MisrWidth-2:0], 1'b0}
            ^ (sig_q[MisrWidth-1] ? Poly : '0)
            ^ MisrWidth'(data_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         sig_q <= '0;
      end else if (en_i) begin
         sig_q <= sig_n;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_ctrl
// Logic-BIST controller: PRPG feeds the scan chains, a MISR compacts their
// outputs, a fixed number of shift/capture patterns is applied, and the final
// signature is compared with golden_i.
// Optional feature (macro LBIST_ABORT_EN): adds abort_i, which ends a busy
// run at the next edge with done_o=1, pass_o=0 and the MISR frozen.
// Ports:
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset, aborts any run
//   start_i      in   start pulse, sampled in IDLE only
//   abort_i      in   (LBIST_ABORT_EN only) abort a busy run
//   golden_i     in   expected signature, sampled in COMPARE
//   scan_en_o    out  scan enable to all chains
//   capture_o    out  one-cycle functional capture enable
//   scan_in_o    out  serial data into the chains
//   scan_out_i   in   serial data out of the chains
//   busy_o       out  high in every state except IDLE
//   done_o       out  sticky completion flag
//   pass_o       out  sticky result, valid when done_o=1
//   signature_o  out  current MISR contents
//   state_o      out  current FSM state (debug)
// Handshake: start_i is a level sampled only while IDLE; holding it high
// across a run has no effect until the FSM returns to IDLE.
// -----------------------------------------------------------------------------
module lbist_ctrl
   import lbist_pkg::*;
#(
   parameter int                   NumChains  = 8,
   parameter int                   ChainLen   = 64,
   parameter int                   PatternCnt = 1024,
   parameter int                   LfsrWidth  = 32,
   parameter int                   MisrWidth  = 32,
   parameter logic [LfsrWidth-1:0] Seed       = LfsrWidth'(DEFAULT_SEED)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
`ifdef LBIST_ABORT_EN
   input  logic                 abort_i,
`endif
   input  logic [MisrWidth-1:0] golden_i,
   output logic                 scan_en_o,
   output logic                 capture_o,
   output logic [NumChains-1:0] scan_in_o,
   input  logic [NumChains-1:0] scan_out_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [MisrWidth-1:0] signature_o,
   output lbist_state_e         state_o
);

   localparam int ShiftW = $clog2(ChainLen + 1);
   localparam int PatW   = $clog2(PatternCnt + 1);
   localparam logic [ShiftW-1:0] ShiftLast = ShiftW'(ChainLen - 1);
   localparam logic [PatW-1:0]   PatLast   = PatW'(PatternCnt);

   lbist_state_e         state_q, state_n;
   logic [ShiftW-1:0]    shift_cnt_q, shift_cnt_n;
   logic [PatW-1:0]      pat_cnt_q, pat_cnt_n;
   logic [LfsrWidth-1:0] lfsr_q, lfsr_n;
   logic                 done_q, done_n;
   logic                 pass_q, pass_n;
   logic                 misr_clear;
   logic                 misr_en;
   logic [MisrWidth-1:0] misr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
         lfsr_q      <= Seed;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         shift_cnt_q <= shift_cnt_n;
         pat_cnt_q   <= pat_cnt_n;
         lfsr_q      <= lfsr_n;
         done_q      <= done_n;
         pass_q      <= pass_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      shift_cnt_n = shift_cnt_q;
      pat_cnt_n   = pat_cnt_q;
      lfsr_n      = lfsr_q;
      done_n      = done_q;
      pass_n      = pass_q;
      misr_clear  = 1'b0;
      misr_en     = 1'b0;
      scan_en_o   = 1'b0;
      capture_o   = 1'b0;
      scan_in_o   = '0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_n = INIT;
               done_n  = 1'b0;
               pass_n  = 1'b0;
            end
         end
         INIT: begin
            lfsr_n      = Seed;
            misr_clear  = 1'b1;
            pat_cnt_n   = '0;
            shift_cnt_n = '0;
            state_n     = SHIFT;
         end
         SHIFT: begin
            scan_en_o = 1'b1;
            scan_in_o = lfsr_q[NumChains-1:0];
            lfsr_n    = lfsr_step(lfsr_q);
            // Before the first capture the chains hold power-up garbage.
            misr_en   = (pat_cnt_q != '0);
            if (shift_cnt_q == ShiftLast) begin
               shift_cnt_n = '0;
               state_n     = CAPTURE;
            end else begin
               shift_cnt_n = shift_cnt_q + ShiftW'(1);
            end
         end
         CAPTURE: begin
            capture_o   = 1'b1;
            pat_cnt_n   = pat_cnt_q + PatW'(1);
            shift_cnt_n = '0;
            state_n     = (pat_cnt_n == PatLast) ? UNLOAD : SHIFT;
         end
         UNLOAD: begin
            scan_en_o = 1'b1;
            misr_en   = 1'b1;
            if (shift_cnt_q == ShiftLast) begin
               shift_cnt_n = '0;
               state_n     = COMPARE;
            end else begin
               shift_cnt_n = shift_cnt_q + ShiftW'(1);
            end
         end
         COMPARE: begin
            pass_n  = (misr == golden_i);
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

`ifdef LBIST_ABORT_EN
      // Abort wins over the normal sequence; signature and PRPG freeze.
      if (abort_i && (state_q != IDLE)) begin
         state_n    = IDLE;
         done_n     = 1'b1;
         pass_n     = 1'b0;
         lfsr_n     = lfsr_q;
         misr_en    = 1'b0;
         misr_clear = 1'b0;
      end
`endif
   end

   lbist_misr #(
      .MisrWidth (MisrWidth),
      .NumIn     (NumChains)
   ) u_misr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (misr_clear),
      .en_i    (misr_en),
      .data_i  (scan_out_i),
      .sig_o   (misr)
   );

   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign signature_o = misr;
   assign state_o     = state_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbist_ctrl
// Directed bench for lbist_ctrl with NumChains=2, ChainLen=4, PatternCnt=3.
// A 2x4-flop chain model (capture inverts contents) sits on the scan ports;
// an independent software model of PRPG, chains and MISR yields golden values.
// -----------------------------------------------------------------------------
module tb_lbist_ctrl;
   import lbist_pkg::*;

   localparam int NC = 2;
   localparam int CL = 4;
   localparam int PC = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start;
`ifdef LBIST_ABORT_EN
   logic          abort;
`endif
   logic [31:0]   golden;
   logic          scan_en;
   logic          capture;
   logic [NC-1:0] scan_in;
   logic [NC-1:0] scan_out;
   logic          busy;
   logic          done;
   logic          pass;
   logic [31:0]   sig;
   lbist_state_e  state;

   lbist_ctrl #(
      .NumChains  (NC),
      .ChainLen   (CL),
      .PatternCnt (PC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
`ifdef LBIST_ABORT_EN
      .abort_i     (abort),
`endif
      .golden_i    (golden),
      .scan_en_o   (scan_en),
      .capture_o   (capture),
      .scan_in_o   (scan_in),
      .scan_out_i  (scan_out),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .signature_o (sig),
      .state_o     (state)
   );

   // ---------------- scan chain model ----------------
   logic [3:0] c0 = 4'hA;
   logic [3:0] c1 = 4'h5;
   logic       chain_on;
   logic       flip_en;
   int         cap_seen = 0;

   assign scan_out = chain_on ? {c1[3], c0[3]} : 2'b00;

   always @(posedge clk) begin
      if (!busy) cap_seen <= 0;
      if (capture) begin
         c0       <= ~c0 ^ ((flip_en && cap_seen == 1) ? 4'b0100 : 4'b0000);
         c1       <= ~c1;
         cap_seen <= cap_seen + 1;
      end else if (scan_en) begin
         c0 <= {c0[2:0], scan_in[0]};
         c1 <= {c1[2:0], scan_in[1]};
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [31:0] ref_misr(input logic [31:0] m, input logic [1:0] d);
      return {m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'h0) ^ {30'h0, d};
   endfunction

   function automatic logic [31:0] ref_signature(input bit flip);
      logic [31:0] l;
      logic [31:0] m;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [1:0]  o;
      l = 32'hACE1_0001;
      m = 32'h0;
      a = 4'h0;
      b = 4'h0;
      for (int p = 0; p < PC; p++) begin
         for (int s = 0; s < CL; s++) begin
            o = {b[3], a[3]};
            if (p != 0) m = ref_misr(m, o);
            a = {a[2:0], l[0]};
            b = {b[2:0], l[1]};
            l = ref_lfsr(l);
         end
         a = ~a;
         b = ~b;
         if (flip && p == 1) a[2] = ~a[2];
      end
      for (int s = 0; s < CL; s++) begin
         o = {b[3], a[3]};
         m = ref_misr(m, o);
         a = {a[2:0], 1'b0};
         b = {b[2:0], 1'b0};
      end
      return m;
   endfunction

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_state"},   32'(state),   32'(IDLE));
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      check({tag, "_pass"},    32'(pass),    32'd0);
      check({tag, "_sig"},     sig,          32'd0);
      check({tag, "_scan_en"}, 32'(scan_en), 32'd0);
      check({tag, "_capture"}, 32'(capture), 32'd0);
      check({tag, "_scan_in"}, 32'(scan_in), 32'd0);
   endtask

   // ---------------- driver ----------------
   int busy_cyc;
   int cap_cnt;
   int cap_at[4];
   int done_at;
   int done_early;

   // Entered at a negedge with the FSM idle. Cycle n is sampled at the
   // negedge after the n-th rising edge following the start request.
   task automatic run_start(input bit hold);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      busy_cyc   = 0;
      cap_cnt    = 0;
      done_at    = 0;
      done_early = 0;
      for (int i = 0; i < 4; i++) cap_at[i] = 0;
      for (int n = 1; n <= 60; n++) begin
         if (!busy) begin
            done_at = done ? n : -1;
            break;
         end
         busy_cyc++;
         if (done) done_early++;
         if (capture) begin
            if (cap_cnt < 4) cap_at[cap_cnt] = n;
            cap_cnt++;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      golden   = 32'h0;
      chain_on = 1'b0;
      flip_en  = 1'b0;
`ifdef LBIST_ABORT_EN
      abort    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_state", 32'(state), 32'(IDLE));

      // Latency and zero response
      golden = 32'h0;
      run_start(1'b0);
      check("lat_busy_cycles", busy_cyc, 32'd21);
      check("lat_capture_cnt", cap_cnt, 32'd3);
      check("lat_first_cap",   cap_at[0], 32'd6);
      check("lat_cap_gap1",    cap_at[1] - cap_at[0], 32'd5);
      check("lat_cap_gap2",    cap_at[2] - cap_at[1], 32'd5);
      check("lat_done_cycle",  done_at, 32'd22);
      check("lat_done_early",  done_early, 32'd0);
      check("zero_pass",       32'(pass), 32'd1);
      check("zero_sig",        sig, 32'd0);

      golden = 32'h1;
      run_start(1'b0);
      check("zero_bad_golden_done", 32'(done), 32'd1);
      check("zero_bad_golden_pass", 32'(pass), 32'd0);

      // Chain model with reference golden
      chain_on = 1'b1;
      golden   = ref_signature(1'b0);
      run_start(1'b0);
      check("chain_done", 32'(done), 32'd1);
      check("chain_pass", 32'(pass), 32'd1);
      check("chain_sig",  sig, ref_signature(1'b0));

      // Single flop upset at pattern 2
      flip_en = 1'b1;
      run_start(1'b0);
      check("flip_pass", 32'(pass), 32'd0);
      check("flip_sig",  sig, ref_signature(1'b1));
      flip_en = 1'b0;

      // start held high for the whole run
      run_start(1'b1);
      check("hold_busy_cycles", busy_cyc, 32'd21);
      check("hold_capture_cnt", cap_cnt, 32'd3);
      check("hold_pass",        32'(pass), 32'd1);
      repeat (5) @(negedge clk);
      check("hold_stays_idle",  32'(busy), 32'd0);
      run_start(1'b0);
      check("restart_busy_cycles", busy_cyc, 32'd21);
      check("restart_pass",        32'(pass), 32'd1);

      // Reset during the third SHIFT cycle
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_in_shift", 32'(state), 32'(SHIFT));
      rst = 1'b1;
      @(negedge clk);
      check_idle_zero("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      run_start(1'b0);
      check("rst_rerun_sig",  sig, ref_signature(1'b0));
      check("rst_rerun_pass", 32'(pass), 32'd1);

`ifdef LBIST_ABORT_EN
      // Abort in the CAPTURE of pattern 2
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_in_capture", 32'(capture), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_state", 32'(state), 32'(IDLE));
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_done",  32'(done), 32'd1);
      check("abort_pass",  32'(pass), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
